// File: rtl/gray_cnt_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gray_pkg
//  Description : Shared types and helpers for the Gray counter arbiter.
//                FSM state encoding, bus widths and a popcount helper.
//  Revision    : 1.0  initial release
// ============================================================================
package gray_pkg;

  localparam int GRAY_W = 5;
  localparam int NREQ   = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GRANT = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Number of set bits in a 32-bit word; callers zero-extend narrower values.
  function automatic logic [31:0] popcount(input logic [31:0] v);
    logic [31:0] cnt;
    cnt = '0;
    for (int i = 0; i < 32; i++) begin
      cnt = cnt + 32'(v[i]);
    end
    return cnt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gray_cnt_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : gray_cnt_arbiter_if
//  Description : Request / burst / counter-watch bundle between the
//                requesting logic, the Gray counter and the arbiter.
//                master : requesters + counter output (drive req, len*, gray_in)
//                slave  : arbiter (drives cnt_enable, grant, done, busy, gray_err)
//  Revision    : 1.0  initial release
// ============================================================================
interface gray_cnt_arbiter_if
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_W
);
  logic [NREQ-1:0]  req;
  logic [WIDTH-1:0] len0;
  logic [WIDTH-1:0] len1;
  logic [WIDTH-1:0] gray_in;
  logic             cnt_enable;
  logic [NREQ-1:0]  grant;
  logic [NREQ-1:0]  done;
  logic             busy;
  logic             gray_err;

  modport master (
    output req, len0, len1, gray_in,
    input  cnt_enable, grant, done, busy, gray_err
  );

  modport slave (
    input  req, len0, len1, gray_in,
    output cnt_enable, grant, done, busy, gray_err
  );
endinterface
`default_nettype wire

// File: rtl/gray_cnt_arbiter_gray_step_checker.sv
`default_nettype none
// ============================================================================
//  Module      : gray_step_checker
//  Description : Watches a Gray counter output and raises a sticky error if
//                any enabled step changes other than exactly one bit.
//  Ports       : clk, reset_L (async, active low)
//                gray_in  - counter output being watched
//                enable   - the counter's enable (step expected next edge)
//                gray_err - sticky violation flag, cleared only by reset
//  Revision    : 1.0  initial release
// ============================================================================
module gray_step_checker
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_W
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             enable,
  output logic             gray_err
);

  logic [WIDTH-1:0] prev_gray_q, prev_gray_d;
  logic             en_d_q, en_d_d;   // enable delayed to line up with the step
  logic             err_q, err_d;
  logic             step_ok;

  always_comb begin
    prev_gray_d = gray_in;
    en_d_d      = enable;
    step_ok     = (popcount(32'(gray_in ^ prev_gray_q)) == 32'd1);
    // The counter moved on the edge where en_d was captured, so the value now
    // on gray_in must differ from the captured previous one by exactly a bit.
    err_d       = err_q | (en_d_q & ~step_ok);
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      prev_gray_q <= '0;
      en_d_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      prev_gray_q <= prev_gray_d;
      en_d_q      <= en_d_d;
      err_q       <= err_d;
    end
  end

  assign gray_err = err_q;

endmodule
`default_nettype wire

// File: rtl/gray_cnt_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : gray_cnt_arbiter
//  Description : Round-robin arbiter / burst sequencer for a shared Gray
//                counter. Grants one of two requesters, enables the counter
//                for exactly the granted burst length, pulses done to the
//                owner and checks every counter step is a single-bit change.
//  Ports       : clk, reset_L (async, active low)
//                bus (slave) : req, len0, len1, gray_in in;
//                              cnt_enable, grant, done, busy, gray_err out
//  Revision    : 1.0  initial release
// ============================================================================
module gray_cnt_arbiter
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_W
) (
  input  logic                clk,
  input  logic                reset_L,
  gray_cnt_arbiter_if.slave   bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] remaining_q, remaining_d;
  logic             last_q, last_d;     // index of the last requester served
  logic             owner_q, owner_d;   // index of the current owner
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [NREQ-1:0]  done_q, done_d;
  logic             cnt_en_q, cnt_en_d;
  logic             busy_q, busy_d;
  logic             win;
  logic             gray_err_w;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    last_d      = last_q;
    owner_d     = owner_q;
    grant_d     = grant_q;
    done_d      = '0;
    cnt_en_d    = cnt_en_q;
    busy_d      = busy_q;

    // Under contention the requester that was not served last wins.
    win = (bus.req == 2'b11) ? ~last_q : bus.req[1];

    unique case (state_q)
      ST_IDLE: begin
        if (|bus.req) begin
          owner_d = win;
          grant_d = {win, ~win};
          busy_d  = 1'b1;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        remaining_d = owner_q ? bus.len1 : bus.len0;
        if (remaining_d == '0) begin
          done_d  = grant_q;
          state_d = ST_DONE;
        end else begin
          cnt_en_d = 1'b1;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        remaining_d = remaining_q - WIDTH'(1);
        if (remaining_q == WIDTH'(1)) begin
          cnt_en_d = 1'b0;
          state_d  = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Counter is idle this cycle so its final step is visible on gray_in.
        done_d  = grant_q;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        last_d  = owner_q;
        grant_d = '0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      last_q      <= 1'b1;
      owner_q     <= 1'b0;
      grant_q     <= '0;
      done_q      <= '0;
      cnt_en_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      cnt_en_q    <= cnt_en_d;
      busy_q      <= busy_d;
    end
  end

  gray_step_checker #(
    .WIDTH (WIDTH)
  ) u_checker (
    .clk      (clk),
    .reset_L  (reset_L),
    .gray_in  (bus.gray_in),
    .enable   (cnt_en_q),
    .gray_err (gray_err_w)
  );

  assign bus.cnt_enable = cnt_en_q;
  assign bus.grant      = grant_q;
  assign bus.done       = done_q;
  assign bus.busy       = busy_q;
  assign bus.gray_err   = gray_err_w;

endmodule
`default_nettype wire

// File: tb/tb_gray_cnt_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gray_cnt_arbiter
//  Description : Self-checking bench for gray_cnt_arbiter driving a
//                behavioural 5-bit Gray counter as its load.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_gray_cnt_arbiter;
  import gray_pkg::*;

  localparam int W = GRAY_W;

  typedef struct {
    logic [1:0]   req;
    logic [W-1:0] len0;
    logic [W-1:0] len1;
    logic [1:0]   first;
    logic [1:0]   second;
    logic         err;
  } vec_t;

  typedef struct {
    logic [1:0]   done;
    int           len;
    logic [W-1:0] gray;
    logic         err;
  } exp_t;

  logic clk = 1'b0;
  logic reset_L = 1'b0;
  logic skip = 1'b0;
  logic [W-1:0] cnt_bin_q;
  logic [W-1:0] exp_bin;
  int n_tests = 0;
  int n_fail  = 0;
  int done_count = 0;
  exp_t sb_q[$];
  vec_t vecs[10];

  always #5 clk = ~clk;

  gray_cnt_arbiter_if #(.WIDTH(W)) bus ();

  gray_cnt_arbiter #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus)
  );

  // Counter load: binary count presented as Gray; 'skip' makes a bad step.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) cnt_bin_q <= '0;
    else if (bus.cnt_enable) cnt_bin_q <= cnt_bin_q + (skip ? W'(2) : W'(1));
  end
  assign bus.gray_in = cnt_bin_q ^ (cnt_bin_q >> 1);

  function automatic logic [W-1:0] bin2gray(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_one(input logic [1:0] who, input int len, input logic err);
    exp_t e;
    e.done  = who;
    e.len   = len;
    exp_bin = exp_bin + W'(len);
    e.gray  = bin2gray(exp_bin);
    e.err   = err;
    sb_q.push_back(e);
  endtask

  task automatic push_vec(input vec_t v);
    push_one(v.first, (v.first == 2'b01) ? int'(v.len0) : int'(v.len1), v.err);
    if (v.second != 2'b00)
      push_one(v.second, (v.second == 2'b01) ? int'(v.len0) : int'(v.len1), v.err);
    bus.req  = v.req;
    bus.len0 = v.len0;
    bus.len1 = v.len1;
  endtask

  task automatic finish_vec(input vec_t v);
    logic [1:0] pending;
    int guard;
    pending = v.req;
    guard = 0;
    while (pending != 2'b00 && guard < 200) begin
      @(negedge clk);
      guard++;
      if (bus.done != 2'b00) begin
        pending = pending & ~bus.done;
        bus.req = pending;
      end
    end
    if (pending != 2'b00) begin
      check("done_timeout", int'(pending), 0);
      bus.req = 2'b00;
    end
    guard = 0;
    while (bus.busy && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    if (bus.busy) check("idle_timeout", 1, 0);
  endtask

  // Scoreboard side: measure each burst and compare at its done pulse.
  initial begin
    int en_cnt;
    int gcyc;
    logic in_burst;
    exp_t e;
    en_cnt = 0;
    gcyc = 0;
    in_burst = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_L) begin
        in_burst = 1'b0;
        en_cnt = 0;
        gcyc = 0;
      end else begin
        if (bus.grant == 2'b00) begin
          in_burst = 1'b0;
        end else if (!in_burst) begin
          in_burst = 1'b1;
          en_cnt = 0;
          gcyc = 0;
        end
        if (bus.grant != 2'b00) gcyc++;
        if (bus.cnt_enable) en_cnt++;
        if (bus.done != 2'b00) begin
          done_count++;
          if (sb_q.size() == 0) begin
            check("unexpected_done", int'(bus.done), 0);
          end else begin
            e = sb_q.pop_front();
            check("done_owner", int'(bus.done), int'(e.done));
            check("enable_cycles", en_cnt, e.len);
            check("gray_after_burst", int'(bus.gray_in), int'(e.gray));
            check("gray_err_at_done", int'(bus.gray_err), int'(e.err));
            check("grant_cycles", gcyc, (e.len == 0) ? 2 : e.len + 3);
          end
        end
      end
    end
  end

  initial begin
    exp_t e;
    int g;
    int dc;
    //          req    len0   len1   first  second err
    vecs[0] = '{2'b11, 5'd3,  5'd1,  2'b01, 2'b10, 1'b0};
    vecs[1] = '{2'b11, 5'd2,  5'd1,  2'b01, 2'b10, 1'b0};
    vecs[2] = '{2'b01, 5'd1,  5'd0,  2'b01, 2'b00, 1'b0};
    vecs[3] = '{2'b01, 5'd2,  5'd0,  2'b01, 2'b00, 1'b0};
    vecs[4] = '{2'b11, 5'd1,  5'd1,  2'b10, 2'b01, 1'b0};
    vecs[5] = '{2'b10, 5'd0,  5'd0,  2'b10, 2'b00, 1'b0};
    vecs[6] = '{2'b10, 5'd0,  5'd21, 2'b10, 2'b00, 1'b0};
    vecs[7] = '{2'b01, 5'd31, 5'd0,  2'b01, 2'b00, 1'b0};
    vecs[8] = '{2'b01, 5'd1,  5'd0,  2'b01, 2'b00, 1'b0};
    vecs[9] = '{2'b10, 5'd0,  5'd2,  2'b10, 2'b00, 1'b1};

    bus.req  = 2'b00;
    bus.len0 = '0;
    bus.len1 = '0;
    exp_bin  = '0;

    // Reset with both requests pending: everything quiet.
    reset_L = 1'b0;
    push_vec(vecs[0]);
    repeat (3) @(negedge clk);
    check("rst_grant", int'(bus.grant), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_cnt_enable", int'(bus.cnt_enable), 0);
    check("rst_gray_err", int'(bus.gray_err), 0);
    reset_L = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("grant_after_release", int'(bus.grant), 1);
    finish_vec(vecs[0]);

    for (int i = 1; i <= 8; i++) begin
      push_vec(vecs[i]);
      finish_vec(vecs[i]);
    end

    // Bad step: counter jumps 00001 -> 00010 during RUN.
    e.done  = 2'b01;
    e.len   = 3;
    exp_bin = exp_bin + W'(4);
    e.gray  = bin2gray(exp_bin);
    e.err   = 1'b1;
    sb_q.push_back(e);
    bus.req  = 2'b01;
    bus.len0 = 5'd3;
    g = 0;
    while (!bus.cnt_enable && g < 20) begin
      @(negedge clk);
      g++;
    end
    check("err_seq_enable_seen", int'(bus.cnt_enable), 1);
    skip = 1'b1;
    @(negedge clk);
    skip = 1'b0;
    finish_vec('{2'b01, 5'd3, 5'd0, 2'b01, 2'b00, 1'b1});
    check("gray_err_set", int'(bus.gray_err), 1);

    push_vec(vecs[9]);
    finish_vec(vecs[9]);
    check("gray_err_sticky", int'(bus.gray_err), 1);

    // Reset in the second RUN cycle: outputs drop before any clock edge.
    bus.req  = 2'b01;
    bus.len0 = 5'd10;
    g = 0;
    while (!bus.cnt_enable && g < 20) begin
      @(negedge clk);
      g++;
    end
    @(negedge clk);
    check("mid_run_enable_before", int'(bus.cnt_enable), 1);
    #1 reset_L = 1'b0;
    #1;
    check("midrst_cnt_enable", int'(bus.cnt_enable), 0);
    check("midrst_grant", int'(bus.grant), 0);
    check("midrst_busy", int'(bus.busy), 0);
    check("midrst_gray_err", int'(bus.gray_err), 0);
    bus.req = 2'b00;
    exp_bin = '0;
    dc = done_count;
    repeat (2) @(negedge clk);
    reset_L = 1'b1;
    repeat (30) @(negedge clk);
    check("no_done_after_reset", done_count - dc, 0);
    check("scoreboard_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
